// File: rtl/dm_pkg.sv
// dm_pkg: DMCtrl encodings and access-legality helpers for the pipelined data memory.
package dm_pkg;
   typedef logic [2:0] dm_ctrl_t;
   localparam dm_ctrl_t DM_B  = 3'b000;
   localparam dm_ctrl_t DM_H  = 3'b001;
   localparam dm_ctrl_t DM_W  = 3'b010;
   localparam dm_ctrl_t DM_BU = 3'b100;
   localparam dm_ctrl_t DM_HU = 3'b101;
   function automatic logic dm_is_legal(input dm_ctrl_t c);
      return c inside {DM_B, DM_H, DM_W, DM_BU, DM_HU};
   endfunction
   function automatic logic dm_misaligned(input dm_ctrl_t c, input logic [1:0] off);
      return ((c == DM_H || c == DM_HU) && off[0]) || (c == DM_W && off != 2'b00);
   endfunction
endpackage

// File: rtl/dm_load_extend.sv
// dm_load_extend: selects the addressed byte/halfword of a word and sign/zero extends it.
module dm_load_extend
   import dm_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  dm_ctrl_t    ctrl,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      data = ctrl == DM_B  ? {{24{b[7]}}, b} :
             ctrl == DM_BU ? {24'b0, b} :
             ctrl == DM_H  ? {{16{h[15]}}, h} :
             ctrl == DM_HU ? {16'b0, h} : word;
   end
endmodule

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: byte-lane data memory with registered read, fault detection
// and a fixed-latency in-order response pipeline.
module data_memory_pipelined
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1,
   parameter int ADDR_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Req,
   input  logic                  DMWr,
   input  logic [2:0]            DMCtrl,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [31:0]           DataWr,
   output logic                  RespValid,
   output logic                  RespWr,
   output logic                  RespFault,
   output logic [31:0]           DataRd
);
   localparam int IW = $clog2(DEPTH_WORDS);
   typedef struct packed {
      logic        v;
      logic        wr;
      logic        fault;
      dm_ctrl_t    ctrl;
      logic [1:0]  off;
      logic [31:0] word;
   } s0_t;
   typedef struct packed {
      logic        v;
      logic        wr;
      logic        fault;
      logic [31:0] data;
   } resp_t;
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [IW-1:0] idx;
   logic [1:0]    off;
   dm_ctrl_t      ctrl;
   logic          fault;
   logic          st_en;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   ext_data;
   s0_t           s0_d, s0_q;
   resp_t         resp_s [READ_LATENCY];
   // BU/HU encodings store like B/H since only ctrl[1:0] picks the width
   always_comb begin
      ctrl  = DMCtrl;
      off   = Address[1:0];
      idx   = Address[IW+1:2];
      fault = !dm_is_legal(ctrl) || dm_misaligned(ctrl, off) || ((Address >> (IW + 2)) != '0);
      st_en = Req && DMWr && !fault;
      be    = ctrl[1:0] == 2'b10 ? 4'hF : ctrl[0] ? (off[1] ? 4'hC : 4'h3) : 4'b0001 << off;
      wdata = ctrl[1:0] == 2'b10 ? DataWr : ctrl[0] ? {2{DataWr[15:0]}} : {4{DataWr[7:0]}};
      s0_d  = '{v: Req, wr: Req && DMWr, fault: Req && fault, ctrl: ctrl, off: off,
                word: (Req && !DMWr) ? mem_q[idx] : s0_q.word};
   end
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (st_en && be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s0_q <= '0;
      else        s0_q <= s0_d;
   end
   dm_load_extend u_ext (
      .word (s0_q.word),
      .off  (s0_q.off),
      .ctrl (s0_q.ctrl),
      .data (ext_data)
   );
   assign resp_s[0] = '{v: s0_q.v, wr: s0_q.wr, fault: s0_q.fault,
                        data: (s0_q.v && !s0_q.wr && !s0_q.fault) ? ext_data : 32'b0};
   for (genvar i = 1; i < READ_LATENCY; i++) begin : g_stage
      resp_t stage_d, stage_q;
      assign stage_d = resp_s[i-1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) stage_q <= '0;
         else        stage_q <= stage_d;
      end
      assign resp_s[i] = stage_q;
   end
   assign {RespValid, RespWr, RespFault, DataRd} = resp_s[READ_LATENCY-1];
endmodule

// File: doc/data_memory_pipelined.md
Name: data_memory_pipelined

Overview:
Clocked, parametrised successor to the combinational data memory in the MEM stage of the pipelined processor. It keeps the same DMCtrl load/store encoding: byte/half/word, with signed or unsigned loads. It adds synchronous byte-lane writes, configurable depth, a configurable read-pipeline latency, a per-request valid/response handshake, and fault detection for misaligned, out-of-range and illegal-control accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
READ_LATENCY, 1, cycles from accepted request to response; legal range 1..4.
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
Req  input  1  request valid; accepted every cycle it is high, no backpressure.
DMWr  input  1  1 = store, 0 = load.
DMCtrl  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 illegal.
Address  input  ADDR_WIDTH  byte address.
DataWr  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
RespValid  output  1  response for the request accepted READ_LATENCY cycles earlier.
RespWr  output  1  echoes DMWr of that request.
RespFault  output  1  request faulted.
DataRd  output  32  extended load data; 0 for stores and faults.

Behaviour:
- Reset (asynchronous, rst_n low):
  - RespValid, RespWr, RespFault and DataRd are cleared to 0.
  - All pipeline valid bits are cleared; in-flight responses are discarded and never emitted.
  - The memory array is NOT reset; its contents are retained across reset.
- Word index is Address[log2(DEPTH_WORDS)+1:2]; byte offset is Address[1:0].
- Fault conditions, evaluated at accept:
  - H/HU access with Address[0]=1.
  - W access with Address[1:0]!=0.
  - Any Address bit above the word index is nonzero (out of range).
  - Illegal DMCtrl.
  - DMWr=1 with DMCtrl 100 or 101 is legal and equivalent to SB/SH.
- Store (Req & DMWr & no fault):
  - Writes at the accepting rising edge using byte enables:
    - SB: lane Address[1:0] gets DataWr[7:0].
    - SH: lanes {Address[1],0} and {Address[1],1} get DataWr[15:0], little-endian.
    - SW: all four lanes.
  - Untouched lanes keep their contents.
- Faulted store: no array change.
- Load:
  - The array word is read at the accepting edge (registered read).
  - Lane selection and extension:
    - B: sign-extend the byte at the offset.
    - BU: zero-extend the byte at the offset.
    - H: sign-extend the halfword at offset[1].
    - HU: zero-extend the halfword at offset[1].
    - W: whole word.
  - The result passes through READ_LATENCY-1 further register stages.
- Response timing: for a request accepted at edge N, RespValid/RespWr/RespFault/DataRd are valid for exactly one cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1 they are valid in the cycle after the accept edge.
- Throughput: one request per cycle. Responses are emitted in order, one per accepted request; there are no gaps beyond gaps in Req.
- Ordering (read-after-write): a load accepted in any cycle after a store to the same word sees the stored data. There are no same-cycle RAW cases, since there is one port and one op per cycle.
- Req=0: no array access; the corresponding response slot has RespValid=0 and DataRd=0.
- Stores and faults return DataRd=0.

Decomposition:
- Package dm_pkg:
  - DMCtrl encodings as localparams (DM_B, DM_H, DM_W, DM_BU, DM_HU).
  - dm_ctrl_t typedef.
  - Helper functions dm_is_legal and dm_misaligned.
- Sub-module dm_load_extend: combinational lane select plus sign/zero extension (word, offset, DMCtrl -> 32-bit). Instantiated at the first read stage.
- Top level holds:
  - the array;
  - byte-enable generation;
  - the latency shift-register of {valid, wr, fault, ctrl, offset/data}.

Test Plan:
1. SW 0x10 0xDEADBEEF, then loads → responses: LW 0x10 → 0xDEADBEEF; LB 0x10 → 0xFFFFFFEF; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
2. After test 1: SB 0x11 0x000000AA, SH 0x16 0x00001234, then LW 0x10 → 0xDEADAAEF; LW 0x14 → 0x1234xxxx, with the lower half unchanged from the prior value.
3. Faults: LW 0x12, LH 0x11 and DMCtrl=011 each → RespFault=1, DataRd=0. SW 0x12 0xFFFFFFFF, then LW 0x10 → unchanged.
4. With DEPTH_WORDS=16: LW 0x40 → RespFault=1; SW 0x40 → no write; LW 0x3C → RespFault=0.
5. With READ_LATENCY=3: SW 0x20 0x11223344 followed next cycle by LW 0x20 → RespValid at edges N+2 and N+3, DataRd=0x11223344 on the second. Back-to-back 8 loads produce 8 consecutive in-order responses.
6. Assert rst_n low with 2 loads in flight (READ_LATENCY=2) → outputs 0 immediately, no stale responses after release. A subsequent LW of a pre-reset-written word returns the retained data.
